// File: rtl/color_pkg.sv
// color_pkg: shared constants and types for the colour sense decoder.
//   FILT_*  : {s2,s3} filter-select encodings driven to the sensor
//   COL_*   : one-hot colour codes presented on cs
//   state_t : sweep sequencer states
//   chan_t  : channel currently being measured
package color_pkg;
    localparam logic [1:0] FILT_RED   = 2'b00;
    localparam logic [1:0] FILT_BLUE  = 2'b01;
    localparam logic [1:0] FILT_CLEAR = 2'b10;
    localparam logic [1:0] FILT_GREEN = 2'b11;
    localparam logic [2:0] COL_NONE  = 3'b000;
    localparam logic [2:0] COL_RED   = 3'b001;
    localparam logic [2:0] COL_GREEN = 3'b010;
    localparam logic [2:0] COL_BLUE  = 3'b100;
    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, CLASSIFY} state_t;
    typedef enum logic [1:0] {CH_RED, CH_GREEN, CH_BLUE} chan_t;
endpackage

// File: rtl/freq_edge_counter.sv
// freq_edge_counter: synchronizes freq_in, detects rising edges, counts them with saturation.
//   clk, reset : clock, async active-high reset
//   freq_in    : raw sensor pulse train (asynchronous to clk)
//   count_en   : count detected edges while high
//   clr        : force the count to zero
//   count      : count including this cycle's edge, i.e. the value the register takes next
//   sat        : count is at its maximum value
module freq_edge_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             freq_in,
    input  logic             count_en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);
    // sync[1:0] is the two-flop synchronizer, sync[2] the previous synchronized sample
    logic [2:0]       sync;
    logic [CNT_W-1:0] cnt_q;
    logic             edge_det;

    assign edge_det = sync[1] & ~sync[2];
    // Exposing the next value lets the caller capture an edge that lands on the last gate cycle
    assign count = clr ? '0 : (count_en && edge_det && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    assign sat   = &count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync  <= '0;
            cnt_q <= '0;
        end else begin
            sync  <= {sync[1:0], freq_in};
            cnt_q <= count;
        end
    end
endmodule

// File: rtl/color_sense_decoder.sv
// color_sense_decoder: sweeps the sensor filters red/green/blue, counts pulses, classifies colour.
//   clk, reset : clock, async active-high reset
//   enable     : run continuous sweeps while high; dropping it aborts the sweep
//   freq_in    : raw sensor frequency output
//   s2, s3     : registered sensor filter select
//   cs         : one-hot colour (bit0 red, bit1 green, bit2 blue) or zero
//   cs_valid   : one-cycle pulse when cs is updated
//   sat        : sticky, some channel counter saturated during this sweep
module color_sense_decoder
    import color_pkg::*;
#(
    parameter int GATE_CYCLES   = 100000,
    parameter int SETTLE_CYCLES = 10000,
    parameter int CNT_W         = 16,
    parameter int MIN_COUNT     = 20,
    parameter int MARGIN        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       freq_in,
    output logic       s2,
    output logic       s3,
    output logic [2:0] cs,
    output logic       cs_valid,
    output logic       sat
);
    localparam int TW = $clog2(GATE_CYCLES > SETTLE_CYCLES ? GATE_CYCLES : SETTLE_CYCLES) + 1;
    localparam logic [TW-1:0]  GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0]  SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W:0] MIN_V       = (CNT_W + 1)'(MIN_COUNT);
    localparam logic [CNT_W:0] MARGIN_V    = (CNT_W + 1)'(MARGIN);

    state_t           state, state_d;
    chan_t            ch, ch_d;
    logic [1:0]       filt, filt_d;
    logic [TW-1:0]    tmr;
    logic [CNT_W-1:0] cnt_r, cnt_g, cnt_b, count;
    logic [CNT_W:0]   r, g, b, win, run;
    logic [2:0]       win_col, cs_d;
    logic             cnt_sat, sweep_start, count_end;

    freq_edge_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .freq_in (freq_in),
        .count_en(state == COUNT),
        .clr     (state != COUNT),
        .count   (count),
        .sat     (cnt_sat)
    );

    assign s2          = filt[1];
    assign s3          = filt[0];
    assign sweep_start = (state == IDLE || state == CLASSIFY) && state_d == SETTLE;
    assign count_end   = state == COUNT && state_d != COUNT;

    always_comb begin
        state_d = state;
        ch_d    = ch;
        filt_d  = filt;
        case (state)
            IDLE: if (enable) begin
                state_d = SETTLE;
                ch_d    = CH_RED;
                filt_d  = FILT_RED;
            end
            SETTLE: if (!enable) begin
                state_d = IDLE;
                filt_d  = FILT_CLEAR;
            end else if (tmr == SETTLE_LAST) begin
                state_d = COUNT;
            end
            COUNT: if (!enable) begin
                state_d = IDLE;
                filt_d  = FILT_CLEAR;
            end else if (tmr == GATE_LAST) begin
                state_d = (ch == CH_BLUE) ? CLASSIFY : SETTLE;
                ch_d    = (ch == CH_RED) ? CH_GREEN : CH_BLUE;
                filt_d  = (ch == CH_RED) ? FILT_GREEN : (ch == CH_GREEN) ? FILT_BLUE : filt;
            end
            default: begin
                state_d = enable ? SETTLE : IDLE;
                ch_d    = CH_RED;
                filt_d  = enable ? FILT_RED : FILT_CLEAR;
            end
        endcase
    end

    // A strict maximum is required; any tie for first leaves win_col at COL_NONE
    always_comb begin
        r       = {1'b0, cnt_r};
        g       = {1'b0, cnt_g};
        b       = {1'b0, cnt_b};
        win_col = COL_NONE;
        win     = '0;
        run     = '0;
        if (r > g && r > b) begin
            win_col = COL_RED;
            win     = r;
            run     = (g > b) ? g : b;
        end else if (g > r && g > b) begin
            win_col = COL_GREEN;
            win     = g;
            run     = (r > b) ? r : b;
        end else if (b > r && b > g) begin
            win_col = COL_BLUE;
            win     = b;
            run     = (r > g) ? r : g;
        end
        cs_d = (win_col != COL_NONE && win >= MIN_V && win >= run + MARGIN_V) ? win_col : COL_NONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ch       <= CH_RED;
            filt     <= FILT_RED;
            tmr      <= '0;
            cnt_r    <= '0;
            cnt_g    <= '0;
            cnt_b    <= '0;
            cs       <= COL_NONE;
            cs_valid <= 1'b0;
            sat      <= 1'b0;
        end else begin
            state    <= state_d;
            ch       <= ch_d;
            filt     <= filt_d;
            tmr      <= (state_d != state) ? '0 : tmr + 1'b1;
            cs_valid <= state == CLASSIFY;
            if (state == CLASSIFY)
                cs <= cs_d;
            if (state == CLASSIFY || state_d == IDLE) begin
                cnt_r <= '0;
                cnt_g <= '0;
                cnt_b <= '0;
            end else if (count_end) begin
                if (ch == CH_RED)
                    cnt_r <= count;
                else if (ch == CH_GREEN)
                    cnt_g <= count;
                else
                    cnt_b <= count;
            end
            if (sweep_start)
                sat <= 1'b0;
            else if (state == COUNT && cnt_sat)
                sat <= 1'b1;
        end
    end
endmodule

// File: tb/tb_color_sense_decoder.sv
// tb_color_sense_decoder: scoreboard bench for color_sense_decoder with a behavioural sensor model.
module tb_color_sense_decoder;
    localparam int G = 100, S = 10, MINC = 20, MARG = 8;
    localparam int SWEEP = 3 * (S + G) + 1;

    logic clk = 0, reset = 1, enable = 0, enable_s = 0;
    logic gen_f = 0, gen_fs = 0, inj = 0, inj_f = 0;
    logic freq_in, freq_s;
    logic s2, s3, cs_valid, sat, s2_s, s3_s, cs_valid_s, sat_s;
    logic [2:0] cs, cs_s;
    int per_r = 0, per_g = 0, per_b = 0;
    int tests = 0, fails = 0, cyc = 0, vcount = 0, v_cyc = 0, v_prev = 0;
    logic [2:0] exp_q[$];
    logic [1:0] rv_q[$];
    int rl_q[$];
    logic [1:0] run_val = 2'b00;
    int run_len = 0;

    assign freq_in = inj ? inj_f : gen_f;
    assign freq_s  = gen_fs;

    color_sense_decoder #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(8), .MIN_COUNT(MINC), .MARGIN(MARG)) dut (
        .clk(clk), .reset(reset), .enable(enable), .freq_in(freq_in),
        .s2(s2), .s3(s3), .cs(cs), .cs_valid(cs_valid), .sat(sat));

    color_sense_decoder #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(4), .MIN_COUNT(MINC), .MARGIN(MARG)) dut_s (
        .clk(clk), .reset(reset), .enable(enable_s), .freq_in(freq_s),
        .s2(s2_s), .s3(s3_s), .cs(cs_s), .cs_valid(cs_valid_s), .sat(sat_s));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int per_of(input logic [1:0] f);
        return f == 2'b00 ? per_r : f == 2'b11 ? per_g : f == 2'b01 ? per_b : 0;
    endfunction

    // Sensor model: square wave whose period (in clk cycles) depends on the selected filter
    initial begin
        int p;
        #3;
        forever begin
            p = per_of({s2, s3});
            if (p == 0) begin gen_f = 0; #10; end
            else begin gen_f = 1; #(p * 5); gen_f = 0; #(p * 5); end
        end
    end

    initial begin
        int p;
        #4;
        forever begin
            p = per_of({s2_s, s3_s});
            if (p == 0) begin gen_fs = 0; #10; end
            else begin gen_fs = 1; #(p * 5); gen_fs = 0; #(p * 5); end
        end
    end

    function automatic logic [2:0] model(input int pr, input int pg, input int pb, input int w);
        int c[3];
        int best = -1, second = -1, bi = 0, cap = (1 << w) - 1;
        c[0] = pr == 0 ? 0 : G / pr;
        c[1] = pg == 0 ? 0 : G / pg;
        c[2] = pb == 0 ? 0 : G / pb;
        for (int i = 0; i < 3; i++) begin
            if (c[i] > cap) c[i] = cap;
            if (c[i] > best) begin second = best; best = c[i]; bi = i; end
            else if (c[i] > second) second = c[i];
        end
        return (best == second || best < MINC || best < second + MARG) ? 3'b000 : 3'(1 << bi);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if ({s2, s3} == run_val) run_len <= run_len + 1;
        else begin
            rv_q.push_back(run_val);
            rl_q.push_back(run_len);
            run_val <= {s2, s3};
            run_len <= 1;
        end
        if (!reset && cs_valid) begin
            vcount <= vcount + 1;
            v_prev <= v_cyc;
            v_cyc  <= cyc;
            if (exp_q.size() == 0) chk("spurious_valid", 32'(cs_valid), 0);
            else chk("cs", 32'(cs), 32'(exp_q.pop_front()));
        end
    end

    task automatic wait_valid(input int target);
        int n = 0;
        while (vcount < target && n < 2000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("valid_count", vcount, target);
    endtask

    task automatic sweep(input int pr, input int pg, input int pb, input int n);
        int t;
        per_r = pr; per_g = pg; per_b = pb;
        repeat (n) exp_q.push_back(model(pr, pg, pb, 8));
        t = vcount + n;
        @(negedge clk);
        enable = 1;
        wait_valid(t);
        enable = 0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, n;
        logic sp;
        logic [1:0] fv[3];
        int fl[3];
        fv[0] = 2'b00; fv[1] = 2'b11; fv[2] = 2'b01;
        fl[0] = S + G; fl[1] = S + G; fl[2] = S + G + 1;
        repeat (3) @(negedge clk);
        chk("rst_s2", 32'(s2), 0);
        chk("rst_s3", 32'(s3), 0);
        chk("rst_cs", 32'(cs), 0);
        chk("rst_valid", 32'(cs_valid), 0);
        chk("rst_sat", 32'(sat), 0);
        reset = 0;
        repeat (3) @(negedge clk);

        sweep(4, 10, 20, 2);
        chk("sweep_period", v_cyc - v_prev, SWEEP);

        rv_q.delete(); rl_q.delete();
        sweep(20, 10, 4, 1);
        if (rv_q.size() < 4) chk("filt_runs", rv_q.size(), 4);
        else for (int i = 0; i < 3; i++) begin
            chk("filt_sel", 32'(rv_q[i + 1]), 32'(fv[i]));
            chk("filt_len", rl_q[i + 1], fl[i]);
        end

        sweep(5, 5, 5, 1);
        sweep(5, 6, 6, 1);
        sweep(50, 50, 50, 1);

        per_r = 0; per_g = 0; per_b = 0;
        exp_q.push_back(3'b000);
        t = vcount + 1;
        inj = 1;
        @(negedge clk);
        enable = 1;
        for (int ph = 0; ph < 3; ph++) begin
            repeat (2) begin
                inj_f = 1; @(negedge clk);
                inj_f = 0; @(negedge clk);
            end
            repeat (S + G - 4) @(negedge clk);
        end
        wait_valid(t);
        enable = 0;
        inj = 0;
        repeat (3) @(negedge clk);

        sweep(4, 10, 20, 1);

        t = vcount;
        @(negedge clk);
        enable = 1;
        n = 0;
        while ({s2, s3} != 2'b11 && n < 400) begin @(negedge clk); n++; end
        chk("abort_reach_green", 32'({s2, s3}), 32'(2'b11));
        repeat (S + 50) @(negedge clk);
        enable = 0;
        @(negedge clk);
        chk("abort_filt", 32'({s2, s3}), 32'(2'b10));
        chk("abort_cs", 32'(cs), 32'(3'b001));
        repeat (400) @(negedge clk);
        #1;
        chk("abort_no_valid", vcount, t);
        chk("abort_cs_hold", 32'(cs), 32'(3'b001));

        per_r = 2; per_g = 2; per_b = 2;
        @(negedge clk);
        enable_s = 1;
        n = 0; sp = 0;
        @(negedge clk);
        while (!cs_valid_s && n < 2000) begin
            sp = sat_s;
            @(negedge clk);
            n++;
        end
        chk("sat_valid_seen", 32'(cs_valid_s), 1);
        chk("sat_in_sweep", 32'(sp), 1);
        chk("sat_cs", 32'(cs_s), 32'(model(2, 2, 2, 4)));
        chk("sat_cleared", 32'(sat_s), 0);
        per_r = 0; per_g = 0; per_b = 0;
        repeat (200) @(negedge clk);
        chk("sat_stays_clear", 32'(sat_s), 0);
        enable_s = 0;
        repeat (3) @(negedge clk);

        per_r = 4; per_g = 10; per_b = 20;
        enable = 1;
        repeat (S + 50) @(negedge clk);
        chk("pre_reset_filt", 32'({s2, s3}), 32'(2'b00));
        #2 reset = 1;
        #1;
        chk("mid_rst_cs", 32'(cs), 0);
        chk("mid_rst_s2", 32'(s2), 0);
        chk("mid_rst_s3", 32'(s3), 0);
        chk("mid_rst_sat", 32'(sat), 0);
        enable = 0;
        @(negedge clk);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("post_rst_cs", 32'(cs), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
